rx_framing_parser: RTL and testbench

//  Parametrised RX framing parser between lane deskew and data-link layer. Per cycle, scans a

---
 rtl/pcie_phy_pkg.sv | 31 +++
 rtl/framing_byte_step.sv | 124 ++++++++++++
 rtl/rx_framing_parser.sv | 172 +++++++++++++++++
 tb/tb_rx_framing_parser.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// Shared PHY framing constants and the frame-tracking state type used by the RX parser.
package pcie_phy_pkg;

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    localparam logic [7:0] TOK_SDP0 = 8'hF0;
    localparam logic [7:0] TOK_SDP1 = 8'hAC;
    localparam logic [7:0] TOK_EDB  = 8'hC0;
    localparam logic [7:0] TOK_IDL  = 8'h00;

    localparam logic [10:0] STP_MIN_LEN = 11'd5;

    // STP1/SDP1 hold a token whose second byte lands in the next cycle; EDB is the
    // post-TLP window where cnt counts 0xC0 bytes seen so far.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TLP,
        ST_DLLP,
        ST_STP1,
        ST_SDP1,
        ST_EDB
    } frame_state_e;

    function automatic logic [10:0] stp_len(input logic [3:0] lo, input logic [6:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/framing_byte_step.sv
// One byte of the framing scan: consumes the running frame state and emits the byte's flags.
module framing_byte_step
    import pcie_phy_pkg::*;
#(
    parameter int unsigned CNT_W = 14
) (
    input  logic             gen3_i,
    input  logic             byte_vld_i,
    input  logic [7:0]       byte_i,
    input  logic             k_i,
    input  logic             nxt_vld_i,
    input  logic [7:0]       nxt_byte_i,
    input  frame_state_e     st_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [3:0]       lo_i,
    output frame_state_e     st_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [3:0]       lo_o,
    output logic             vld_o,
    output logic             tlps_o,
    output logic             tlpe_o,
    output logic             edb_o,
    output logic             dlps_o,
    output logic             dlpe_o,
    output logic             err_o
);

    logic [10:0] len;
    logic        do_idle;

    always_comb begin
        st_o    = st_i;
        cnt_o   = cnt_i;
        lo_o    = lo_i;
        vld_o   = 1'b0;
        tlps_o  = 1'b0;
        tlpe_o  = 1'b0;
        edb_o   = 1'b0;
        dlps_o  = 1'b0;
        dlpe_o  = 1'b0;
        err_o   = 1'b0;
        do_idle = 1'b0;
        len     = '0;
        if (byte_vld_i && !gen3_i) begin
            cnt_o = '0;
            case (st_i)
                ST_TLP: begin
                    if (!k_i) vld_o = 1'b1;
                    else if (byte_i == K_END) begin vld_o = 1'b1; tlpe_o = 1'b1; st_o = ST_IDLE; end
                    else if (byte_i == K_EDB) begin vld_o = 1'b1; edb_o = 1'b1; st_o = ST_IDLE; end
                    else begin st_o = ST_IDLE; err_o = 1'b1; end
                end
                ST_DLLP: begin
                    if (!k_i) vld_o = 1'b1;
                    else if (byte_i == K_END) begin vld_o = 1'b1; dlpe_o = 1'b1; st_o = ST_IDLE; end
                    else begin st_o = ST_IDLE; err_o = 1'b1; end
                end
                default: begin
                    st_o = ST_IDLE;
                    if (k_i && byte_i == K_STP) begin st_o = ST_TLP; vld_o = 1'b1; tlps_o = 1'b1; end
                    else if (k_i && byte_i == K_SDP) begin st_o = ST_DLLP; vld_o = 1'b1; dlps_o = 1'b1; end
                    else if (k_i && (byte_i == K_END || byte_i == K_EDB)) err_o = 1'b1;
                end
            endcase
        end else if (byte_vld_i) begin
            case (st_i)
                ST_TLP: begin
                    vld_o = 1'b1;
                    if (cnt_i <= CNT_W'(1)) begin tlpe_o = 1'b1; st_o = ST_EDB; cnt_o = '0; end
                    else cnt_o = cnt_i - CNT_W'(1);
                end
                ST_DLLP: begin
                    vld_o = 1'b1;
                    if (cnt_i <= CNT_W'(1)) begin dlpe_o = 1'b1; st_o = ST_IDLE; cnt_o = '0; end
                    else cnt_o = cnt_i - CNT_W'(1);
                end
                ST_STP1: begin
                    len = stp_len(lo_i, byte_i[6:0]);
                    if (len < STP_MIN_LEN) begin st_o = ST_IDLE; cnt_o = '0; err_o = 1'b1; end
                    else begin st_o = ST_TLP; cnt_o = CNT_W'({len, 2'b00} - 13'd2); vld_o = 1'b1; end
                end
                ST_SDP1: begin
                    if (byte_i == TOK_SDP1) begin st_o = ST_DLLP; cnt_o = CNT_W'(6); vld_o = 1'b1; end
                    else begin st_o = ST_IDLE; cnt_o = '0; err_o = 1'b1; end
                end
                ST_EDB: begin
                    if (byte_i == TOK_EDB) begin
                        vld_o = 1'b1;
                        if (cnt_i == CNT_W'(3)) begin edb_o = 1'b1; st_o = ST_IDLE; cnt_o = '0; end
                        else cnt_o = cnt_i + CNT_W'(1);
                    end else if (cnt_i != '0) begin
                        st_o = ST_IDLE; cnt_o = '0; err_o = 1'b1;
                    end else do_idle = 1'b1;
                end
                default: do_idle = 1'b1;
            endcase
            // Token start: decide with the next byte when it is in this cycle, else defer.
            if (do_idle) begin
                st_o  = ST_IDLE;
                cnt_o = '0;
                if (byte_i != TOK_IDL) begin
                    if (byte_i[3:0] == 4'hF) begin
                        if (!nxt_vld_i) begin
                            st_o = ST_STP1; lo_o = byte_i[7:4]; vld_o = 1'b1; tlps_o = 1'b1;
                        end else begin
                            len = stp_len(byte_i[7:4], nxt_byte_i[6:0]);
                            if (len < STP_MIN_LEN) err_o = 1'b1;
                            else begin
                                st_o = ST_TLP; cnt_o = CNT_W'({len, 2'b00} - 13'd1);
                                vld_o = 1'b1; tlps_o = 1'b1;
                            end
                        end
                    end else if (byte_i == TOK_SDP0) begin
                        if (!nxt_vld_i) begin st_o = ST_SDP1; vld_o = 1'b1; dlps_o = 1'b1; end
                        else if (nxt_byte_i == TOK_SDP1) begin
                            st_o = ST_DLLP; cnt_o = CNT_W'(7); vld_o = 1'b1; dlps_o = 1'b1;
                        end else err_o = 1'b1;
                    end else err_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rx_framing_parser.sv
// RX framing parser: chains one framing_byte_step per byte lane and registers the result.
module rx_framing_parser
    import pcie_phy_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = 14,
    localparam int unsigned NB_W     = $clog2(MAX_BYTES) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   linkup_i,
    input  logic [2:0]             gen_i,
    input  logic                   in_valid_i,
    input  logic [8*MAX_BYTES-1:0] in_data_i,
    input  logic [MAX_BYTES-1:0]   in_dk_i,
    input  logic [NB_W-1:0]        in_nbytes_i,
    input  logic                   in_datablk_i,
    output logic [8*MAX_BYTES-1:0] out_data_o,
    output logic [MAX_BYTES-1:0]   pl_valid_o,
    output logic [MAX_BYTES-1:0]   pl_tlpstart_o,
    output logic [MAX_BYTES-1:0]   pl_tlpend_o,
    output logic [MAX_BYTES-1:0]   pl_tlpedb_o,
    output logic [MAX_BYTES-1:0]   pl_dlpstart_o,
    output logic [MAX_BYTES-1:0]   pl_dlpend_o,
    output logic                   framing_err_o,
    output frame_state_e           dbg_state_o
);

    frame_state_e           st_q, st_d, st_base;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_base;
    logic [3:0]             lo_q, lo_d;
    logic [2:0]             gen_q;
    logic                   gen3, gen_chg;
    logic [MAX_BYTES-1:0]   byte_vld, vld_c, tlps_c, tlpe_c, edb_c, dlps_c, dlpe_c, err_c;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [MAX_BYTES-1:0]   vld_q, vld_d, tlps_q, tlps_d, tlpe_q, tlpe_d;
    logic [MAX_BYTES-1:0]   edb_q, edb_d, dlps_q, dlps_d, dlpe_q, dlpe_d;
    logic                   err_q, err_d;

    assign gen3     = gen_i >= 3'd3;
    assign gen_chg  = gen_i != gen_q;
    // A generation change silently abandons any frame in flight.
    assign st_base  = gen_chg ? ST_IDLE : st_q;
    assign cnt_base = gen_chg ? '0 : cnt_q;

    for (genvar g = 0; g < MAX_BYTES; g++) begin : g_step
        frame_state_e     st_in, st_out;
        logic [CNT_W-1:0] cnt_in, cnt_out;
        logic [3:0]       lo_in, lo_out;
        logic             nxt_vld;
        logic [7:0]       nxt_byte;

        assign byte_vld[g] = in_nbytes_i > NB_W'(g);
        if (g == 0) begin : g_first
            assign st_in  = st_base;
            assign cnt_in = cnt_base;
            assign lo_in  = lo_q;
        end else begin : g_chain
            assign st_in  = g_step[g-1].st_out;
            assign cnt_in = g_step[g-1].cnt_out;
            assign lo_in  = g_step[g-1].lo_out;
        end
        if (g == MAX_BYTES - 1) begin : g_last
            assign nxt_vld  = 1'b0;
            assign nxt_byte = '0;
        end else begin : g_mid
            assign nxt_vld  = byte_vld[g+1];
            assign nxt_byte = in_data_i[8*(g+1) +: 8];
        end

        framing_byte_step #(.CNT_W(CNT_W)) u_step (
            .gen3_i     (gen3),
            .byte_vld_i (byte_vld[g]),
            .byte_i     (in_data_i[8*g +: 8]),
            .k_i        (in_dk_i[g]),
            .nxt_vld_i  (nxt_vld),
            .nxt_byte_i (nxt_byte),
            .st_i       (st_in),
            .cnt_i      (cnt_in),
            .lo_i       (lo_in),
            .st_o       (st_out),
            .cnt_o      (cnt_out),
            .lo_o       (lo_out),
            .vld_o      (vld_c[g]),
            .tlps_o     (tlps_c[g]),
            .tlpe_o     (tlpe_c[g]),
            .edb_o      (edb_c[g]),
            .dlps_o     (dlps_c[g]),
            .dlpe_o     (dlpe_c[g]),
            .err_o      (err_c[g])
        );
    end

    always_comb begin
        st_d   = st_base;
        cnt_d  = cnt_base;
        lo_d   = lo_q;
        data_d = '0;
        vld_d  = '0;
        tlps_d = '0;
        tlpe_d = '0;
        edb_d  = '0;
        dlps_d = '0;
        dlpe_d = '0;
        err_d  = 1'b0;
        if (!linkup_i) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
            lo_d  = '0;
        end else if (in_valid_i) begin
            data_d = in_data_i;
            if (gen3 && !in_datablk_i) begin
                // Ordered set: only legal between frames.
                err_d = !(st_base == ST_IDLE || (st_base == ST_EDB && cnt_base == '0));
                st_d  = ST_IDLE;
                cnt_d = '0;
            end else begin
                st_d   = g_step[MAX_BYTES-1].st_out;
                cnt_d  = g_step[MAX_BYTES-1].cnt_out;
                lo_d   = g_step[MAX_BYTES-1].lo_out;
                vld_d  = vld_c;
                tlps_d = tlps_c;
                tlpe_d = tlpe_c;
                edb_d  = edb_c;
                dlps_d = dlps_c;
                dlpe_d = dlpe_c;
                err_d  = |err_c;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            lo_q   <= '0;
            gen_q  <= '0;
            data_q <= '0;
            vld_q  <= '0;
            tlps_q <= '0;
            tlpe_q <= '0;
            edb_q  <= '0;
            dlps_q <= '0;
            dlpe_q <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            lo_q   <= lo_d;
            gen_q  <= gen_i;
            data_q <= data_d;
            vld_q  <= vld_d;
            tlps_q <= tlps_d;
            tlpe_q <= tlpe_d;
            edb_q  <= edb_d;
            dlps_q <= dlps_d;
            dlpe_q <= dlpe_d;
            err_q  <= err_d;
        end
    end

    assign out_data_o    = data_q;
    assign pl_valid_o    = vld_q;
    assign pl_tlpstart_o = tlps_q;
    assign pl_tlpend_o   = tlpe_q;
    assign pl_tlpedb_o   = edb_q;
    assign pl_dlpstart_o = dlps_q;
    assign pl_dlpend_o   = dlpe_q;
    assign framing_err_o = err_q;
    assign dbg_state_o   = st_q;

endmodule

// File: tb/tb_rx_framing_parser.sv
// Directed bench for rx_framing_parser with 16-byte cycles: vector table plus reset/linkup/gen sequences.
module tb_rx_framing_parser;
    import pcie_phy_pkg::*;

    localparam int MB   = 16;
    localparam int NB_W = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            linkup = 1'b0;
    logic [2:0]      gen = 3'd1;
    logic            in_valid = 1'b0;
    logic [8*MB-1:0] in_data = '0;
    logic [MB-1:0]   in_dk = '0;
    logic [NB_W-1:0] in_nbytes = '0;
    logic            in_datablk = 1'b0;
    logic [8*MB-1:0] out_data;
    logic [MB-1:0]   pl_valid, pl_tlpstart, pl_tlpend, pl_tlpedb, pl_dlpstart, pl_dlpend;
    logic            framing_err;
    frame_state_e    dbg_state;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [2:0]   gen;
        logic         vld;
        logic         blk;
        logic [4:0]   nb;
        logic [127:0] data;
        logic [15:0]  dk;
        logic [15:0]  e_vld, e_tlps, e_tlpe, e_edb, e_dlps, e_dlpe;
        logic         e_err;
    } vec_t;

    vec_t vecs[$];

    rx_framing_parser #(.MAX_BYTES(MB), .CNT_W(14)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .linkup_i      (linkup),
        .gen_i         (gen),
        .in_valid_i    (in_valid),
        .in_data_i     (in_data),
        .in_dk_i       (in_dk),
        .in_nbytes_i   (in_nbytes),
        .in_datablk_i  (in_datablk),
        .out_data_o    (out_data),
        .pl_valid_o    (pl_valid),
        .pl_tlpstart_o (pl_tlpstart),
        .pl_tlpend_o   (pl_tlpend),
        .pl_tlpedb_o   (pl_tlpedb),
        .pl_dlpstart_o (pl_dlpstart),
        .pl_dlpend_o   (pl_dlpend),
        .framing_err_o (framing_err),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] g, input logic v, input logic b, input logic [4:0] nb,
                                input logic [127:0] d, input logic [15:0] dk,
                                input logic [15:0] ev, input logic [15:0] ets, input logic [15:0] ete,
                                input logic [15:0] eedb, input logic [15:0] eds, input logic [15:0] ede,
                                input logic eerr);
        vec_t r;
        r.gen = g; r.vld = v; r.blk = b; r.nb = nb; r.data = d; r.dk = dk;
        r.e_vld = ev; r.e_tlps = ets; r.e_tlpe = ete; r.e_edb = eedb;
        r.e_dlps = eds; r.e_dlpe = ede; r.e_err = eerr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        gen        = v.gen;
        in_valid   = v.vld;
        in_datablk = v.blk;
        in_nbytes  = v.nb;
        in_data    = v.data;
        in_dk      = v.dk;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".data"}, out_data, '0);
        chk({tag, ".valid"}, pl_valid, '0);
        chk({tag, ".tlpstart"}, pl_tlpstart, '0);
        chk({tag, ".tlpend"}, pl_tlpend, '0);
        chk({tag, ".tlpedb"}, pl_tlpedb, '0);
        chk({tag, ".dlpstart"}, pl_dlpstart, '0);
        chk({tag, ".dlpend"}, pl_dlpend, '0);
        chk({tag, ".err"}, framing_err, '0);
    endtask

    // One cycle: drive at negedge, check registered outputs just after the next posedge.
    task automatic step(input string tag, input vec_t v);
        logic [127:0] exp_data;
        @(negedge clk);
        drive(v);
        exp_q.push_back((v.vld && linkup) ? v.data : 128'h0);
        @(posedge clk);
        #1;
        exp_data = exp_q.pop_front();
        chk({tag, ".data"}, out_data, exp_data);
        chk({tag, ".valid"}, pl_valid, v.e_vld);
        chk({tag, ".tlpstart"}, pl_tlpstart, v.e_tlps);
        chk({tag, ".tlpend"}, pl_tlpend, v.e_tlpe);
        chk({tag, ".tlpedb"}, pl_tlpedb, v.e_edb);
        chk({tag, ".dlpstart"}, pl_dlpstart, v.e_dlps);
        chk({tag, ".dlpend"}, pl_dlpend, v.e_dlpe);
        chk({tag, ".err"}, framing_err, v.e_err);
    endtask

    initial begin
        // Gen1/2 K-code framing
        vecs.push_back(mk(1,1,0,4,  128'hFD0100FB, 16'h0009, 16'h000F,16'h0001,16'h0008,0,0,0,0));
        vecs.push_back(mk(1,1,0,4,  128'h0302015C, 16'h0001, 16'h000F,0,0,0,16'h0001,0,0));
        vecs.push_back(mk(1,1,0,5,  128'hFD07060504, 16'h0010, 16'h001F,0,0,0,0,16'h0010,0));
        vecs.push_back(mk(1,1,0,2,  128'h00FD, 16'h0001, 0,0,0,0,0,0,1));
        vecs.push_back(mk(1,1,0,6,  128'hFD225CFE11FB, 16'h002D, 16'h003F,16'h0001,0,16'h0004,16'h0008,16'h0020,0));
        vecs.push_back(mk(1,1,0,3,  128'h00BCFB, 16'h0003, 16'h0001,16'h0001,0,0,0,0,1));
        vecs.push_back(mk(1,1,0,2,  128'hFD01FB, 16'h0005, 16'h0003,16'h0001,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,  128'hFD, 16'h0001, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,  128'hFD, 16'h0001, 16'h0001,0,16'h0001,0,0,0,0));
        // Gen3 token framing
        vecs.push_back(mk(3,1,1,16, 128'h0F0E0D0C0B0A0908070605040302006F, 0, 16'hFFFF,16'h0001,0,0,0,0,0));
        vecs.push_back(mk(3,1,1,12, 128'hC0C0C0C01716151413121110, 0, 16'h0FFF,0,16'h0080,16'h0800,0,0,0));
        vecs.push_back(mk(3,1,1,16, 128'h252423222120005F060504030201ACF0, 0, 16'hFFFF,16'h0100,0,0,16'h0001,16'h0080,0));
        vecs.push_back(mk(3,1,1,12, 128'h3B3A39383736353433323130, 0, 16'h0FFF,0,16'h0800,0,0,0,0));
        vecs.push_back(mk(3,1,1,4,  128'h0000003F, 0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(3,1,1,2,  128'h5F00, 0, 16'h0002,16'h0002,0,0,0,0,0));
        vecs.push_back(mk(3,1,1,16, 128'h0F0E0D0C0B0A09080706050403020100, 0, 16'hFFFF,0,0,0,0,0,0));
        vecs.push_back(mk(3,1,1,4,  128'h00AABBCC, 0, 16'h0007,0,16'h0004,0,0,0,0));
        vecs.push_back(mk(3,1,0,16, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(3,1,1,4,  128'h2211006F, 0, 16'h000F,16'h0001,0,0,0,0,0));
        vecs.push_back(mk(3,1,0,16, 128'h55555555555555555555555555555555, 0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(3,1,1,2,  128'h0000, 0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(3,1,1,1,  128'hF0, 0, 16'h0001,0,0,0,16'h0001,0,0));
        vecs.push_back(mk(3,1,1,8,  128'h00060504030201AC, 0, 16'h007F,0,0,0,0,16'h0040,0));
        vecs.push_back(mk(3,1,1,1,  128'h55, 0, 0,0,0,0,0,0,1));

        // Clock/reset
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        chk("reset.state", dbg_state, ST_IDLE);
        @(negedge clk);
        rst_n  = 1'b1;
        linkup = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of a TLP
        step("rst.start", mk(1,1,0,2, 128'h01FB, 16'h0001, 16'h0003,16'h0001,0,0,0,0,0));
        @(negedge clk);
        drive(mk(1,1,0,1, 128'hFD, 16'h0001, 0,0,0,0,0,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst.async");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst.after");
        step("rst.end_idle", mk(1,1,0,1, 128'hFD, 16'h0001, 0,0,0,0,0,0,1));
        step("rst.restart",  mk(1,1,0,1, 128'hFB, 16'h0001, 16'h0001,16'h0001,0,0,0,0,0));
        step("rst.close",    mk(1,1,0,1, 128'hFD, 16'h0001, 16'h0001,0,16'h0001,0,0,0,0));

        // linkup drop mid-frame discards it without an error
        step("lnk.start", mk(1,1,0,2, 128'h01FB, 16'h0001, 16'h0003,16'h0001,0,0,0,0,0));
        linkup = 1'b0;
        step("lnk.down",  mk(1,1,0,1, 128'hFD, 16'h0001, 0,0,0,0,0,0,0));
        linkup = 1'b1;
        step("lnk.idle",  mk(1,1,0,1, 128'hFD, 16'h0001, 0,0,0,0,0,0,1));

        // Gen change mid-frame returns to IDLE with no error
        step("gen.start", mk(3,1,1,2, 128'h006F, 0, 16'h0003,16'h0001,0,0,0,0,0));
        step("gen.chg",   mk(1,1,0,1, 128'h00, 0, 0,0,0,0,0,0,0));
        step("gen.stp",   mk(1,1,0,1, 128'hFB, 16'h0001, 16'h0001,16'h0001,0,0,0,0,0));
        step("gen.end",   mk(1,1,0,1, 128'hFD, 16'h0001, 16'h0001,0,16'h0001,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
